branch_predictor: RTL and testbench

//  Dynamic gshare branch predictor feeding the decode-stage control decoder's branchpredicted input.

---
 rtl/branch_predictor_pkg.sv | 23 ++
 rtl/branch_predictor_if.sv | 30 +++
 rtl/branch_predictor_bht_ram.sv | 27 ++
 rtl/branch_predictor.sv | 115 +++++++++++
 tb/tb_branch_predictor.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the gshare branch predictor and its neighbours.
package branch_predictor_pkg;

    localparam int unsigned PC_W = 32;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } bp_cnt_e;

    typedef enum logic {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_e;

    // A zero-length history still needs a one-bit carrier on the pipeline.
    function automatic int unsigned ghr_width(input int unsigned ghr_bits);
        return (ghr_bits == 0) ? 1 : ghr_bits;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Decode lookup, execute update and status bundle between the pipeline and the predictor.
interface branch_predictor_if #(
    parameter int unsigned GHR_W = 8,
    parameter int unsigned CNT_W = 32
);
    logic                                lookup_valid;
    logic [branch_predictor_pkg::PC_W-1:0] lookup_pc;
    logic                                branchpredicted;
    logic [GHR_W-1:0]                    lookup_ghr;
    logic                                update_valid;
    logic [branch_predictor_pkg::PC_W-1:0] update_pc;
    logic [GHR_W-1:0]                    update_ghr;
    logic                                update_taken;
    logic                                update_predicted;
    logic                                init_busy;
    logic [CNT_W-1:0]                    branch_count;
    logic [CNT_W-1:0]                    mispredict_count;

    modport master (
        output lookup_valid, lookup_pc,
        output update_valid, update_pc, update_ghr, update_taken, update_predicted,
        input  branchpredicted, lookup_ghr, init_busy, branch_count, mispredict_count
    );

    modport slave (
        input  lookup_valid, lookup_pc,
        input  update_valid, update_pc, update_ghr, update_taken, update_predicted,
        output branchpredicted, lookup_ghr, init_busy, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor_bht_ram.sv
// Branch history table: 2-bit counters, async reads for lookup and update, one sync write.
module branch_predictor_bht_ram #(
    parameter int unsigned IDX_BITS = 8
) (
    input  logic                clk,
    input  logic [IDX_BITS-1:0] lookup_addr,
    output logic [1:0]          lookup_data_c,
    input  logic [IDX_BITS-1:0] update_addr,
    output logic [1:0]          update_data_c,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_addr,
    input  logic [1:0]          wr_data
);
    localparam int unsigned DEPTH = 1 << IDX_BITS;

    logic [1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign lookup_data_c = mem_q[lookup_addr];
    assign update_data_c = mem_q[update_addr];

endmodule

// File: rtl/branch_predictor.sv
// Gshare predictor: zero-latency lookup, execute-time training, table clear after reset, stats.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned IDX_BITS = 8,
    parameter int unsigned GHR_BITS = 8,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    branch_predictor_if.slave bp
);
    localparam int unsigned GHR_W = ghr_width(GHR_BITS);

    bp_state_e           state_q, state_d;
    logic [IDX_BITS-1:0] ptr_q, ptr_d;
    logic [GHR_W-1:0]    ghr_q, ghr_d;
    logic [CNT_W-1:0]    branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]    mispred_cnt_q, mispred_cnt_d;

    logic [IDX_BITS-1:0] lookup_idx_c, update_idx_c, wr_addr_c;
    logic [1:0]          lookup_cnt_c, update_cnt_c, wr_data_c;
    logic                wr_en_c;
    logic                unused_pc_bits_c;

    function automatic logic [IDX_BITS-1:0] hash_idx(input logic [PC_W-1:0]  pc,
                                                      input logic [GHR_W-1:0] ghr);
        logic [IDX_BITS-1:0] hist;
        hist = (GHR_BITS == 0) ? '0 : IDX_BITS'(ghr);
        return pc[IDX_BITS+1:2] ^ hist;
    endfunction

    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == CNT_ST) ? cnt : cnt + 2'd1;
        end
        return (cnt == CNT_SNT) ? cnt : cnt - 2'd1;
    endfunction

    assign lookup_idx_c = hash_idx(bp.lookup_pc, ghr_q);
    assign update_idx_c = hash_idx(bp.update_pc, bp.update_ghr);
    assign unused_pc_bits_c = ^{bp.lookup_pc[PC_W-1:IDX_BITS+2], bp.lookup_pc[1:0],
                                bp.update_pc[PC_W-1:IDX_BITS+2], bp.update_pc[1:0]};

    branch_predictor_bht_ram #(.IDX_BITS(IDX_BITS)) u_bht_ram (
        .clk           (clk),
        .lookup_addr   (lookup_idx_c),
        .lookup_data_c (lookup_cnt_c),
        .update_addr   (update_idx_c),
        .update_data_c (update_cnt_c),
        .wr_en         (wr_en_c),
        .wr_addr       (wr_addr_c),
        .wr_data       (wr_data_c)
    );

    // Init sweep owns the write port; afterwards it carries the trained counter.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        ghr_d         = ghr_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        wr_en_c       = 1'b0;
        wr_addr_c     = ptr_q;
        wr_data_c     = CNT_WNT;
        case (state_q)
            BP_INIT: begin
                wr_en_c = 1'b1;
                ptr_d   = ptr_q + IDX_BITS'(1);
                if (ptr_q == '1) begin
                    state_d = BP_RUN;
                end
            end
            BP_RUN: begin
                if (bp.update_valid) begin
                    wr_en_c   = 1'b1;
                    wr_addr_c = update_idx_c;
                    wr_data_c = cnt_next(update_cnt_c, bp.update_taken);
                    ghr_d     = (GHR_BITS == 0) ? '0 : GHR_W'({ghr_q, bp.update_taken});
                    if (branch_cnt_q != '1) begin
                        branch_cnt_d = branch_cnt_q + CNT_W'(1);
                    end
                    if ((bp.update_taken != bp.update_predicted) && (mispred_cnt_q != '1)) begin
                        mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = BP_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BP_INIT;
            ptr_q         <= '0;
            ghr_q         <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            ghr_q         <= ghr_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Prediction is combinational so decode sees it in the same cycle.
    assign bp.branchpredicted  = bp.lookup_valid & (state_q == BP_RUN) & lookup_cnt_c[1];
    assign bp.lookup_ghr       = ghr_q;
    assign bp.init_busy        = (state_q == BP_INIT);
    assign bp.branch_count     = branch_cnt_q;
    assign bp.mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: default build plus a 4-bit statistics build.
module tb_branch_predictor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_cyc;

    always #5 clk = ~clk;

    branch_predictor_if #(.GHR_W(8), .CNT_W(32)) bp_if ();
    branch_predictor_if #(.GHR_W(8), .CNT_W(4))  bp4_if ();

    branch_predictor dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_if)
    );

    branch_predictor #(.CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bp  (bp4_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_lookup(input logic v, input logic [31:0] pc);
        bp_if.lookup_valid  = v;
        bp_if.lookup_pc     = pc;
        bp4_if.lookup_valid = v;
        bp4_if.lookup_pc    = pc;
    endtask

    task automatic set_upd(input bit en_main, input bit en_b4, input logic [31:0] pc,
                           input logic [7:0] ghr, input logic taken, input logic pred);
        bp_if.update_valid      = en_main;
        bp_if.update_pc         = pc;
        bp_if.update_ghr        = ghr;
        bp_if.update_taken      = taken;
        bp_if.update_predicted  = pred;
        bp4_if.update_valid     = en_b4;
        bp4_if.update_pc        = pc;
        bp4_if.update_ghr       = ghr;
        bp4_if.update_taken     = taken;
        bp4_if.update_predicted = pred;
    endtask

    task automatic pulse_rst;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_init(input bit chk, output int n);
        n = 0;
        while (bp_if.init_busy && n < 2000) begin
            if (chk && (n % 64 == 32)) begin
                set_lookup(1'b1, $urandom);
                #1;
                check("init_lookup", 32'(bp_if.branchpredicted), 32'd0);
            end
            tick();
            n++;
        end
    endtask

    logic [9:0] st_taken = 10'b1101001101;
    logic [9:0] st_pred  = 10'b0101101001;

    initial begin
        set_lookup(1'b0, 32'h0);
        set_upd(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);

        // Reset state and init length, predictions suppressed while clearing.
        pulse_rst();
        set_lookup(1'b1, 32'h100);
        #1;
        check("rst_busy", 32'(bp_if.init_busy), 32'd1);
        check("rst_busy4", 32'(bp4_if.init_busy), 32'd1);
        check("rst_pred", 32'(bp_if.branchpredicted), 32'd0);
        check("rst_ghr", 32'(bp_if.lookup_ghr), 32'd0);
        check("rst_brcnt", bp_if.branch_count, 32'd0);
        check("rst_miscnt", bp_if.mispredict_count, 32'd0);
        wait_init(1'b1, n_cyc);
        check("init_len", 32'(n_cyc), 32'd256);
        check("init_done4", 32'(bp4_if.init_busy), 32'd0);

        // Fresh counter is WNT; one taken update flips it to WT.
        set_lookup(1'b1, 32'h100);
        #1;
        check("fresh_pred", 32'(bp_if.branchpredicted), 32'd0);
        set_upd(1'b1, 1'b1, 32'h100, 8'h00, 1'b1, 1'b0);
        tick();
        set_upd(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        set_lookup(1'b1, 32'h104);
        #1;
        check("ghr_after1", 32'(bp_if.lookup_ghr), 32'h01);
        check("trained_pred", 32'(bp_if.branchpredicted), 32'd1);

        // Saturation at ST and the walk back down.
        for (int i = 0; i < 4; i++) begin
            set_upd(1'b1, 1'b1, 32'h200, 8'h00, 1'b1, 1'b1);
            tick();
        end
        set_upd(1'b1, 1'b1, 32'h200, 8'h00, 1'b0, 1'b1);
        tick();
        set_upd(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        set_lookup(1'b1, 32'h2F8);
        #1;
        check("sat_ghr", 32'(bp_if.lookup_ghr), 32'h3E);
        check("sat_one_nt", 32'(bp_if.branchpredicted), 32'd1);
        set_upd(1'b1, 1'b1, 32'h200, 8'h00, 1'b0, 1'b1);
        tick();
        set_upd(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        set_lookup(1'b1, 32'h3F0);
        #1;
        check("sat_ghr2", 32'(bp_if.lookup_ghr), 32'h7C);
        check("sat_two_nt", 32'(bp_if.branchpredicted), 32'd0);

        // Same-cycle lookup and update to one index reads the old counter.
        set_lookup(1'b1, 32'h1B0);
        set_upd(1'b1, 1'b1, 32'h040, 8'h00, 1'b1, 1'b0);
        #1;
        check("rdold_same", 32'(bp_if.branchpredicted), 32'd0);
        tick();
        set_upd(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        set_lookup(1'b1, 32'h3A4);
        #1;
        check("rdold_ghr", 32'(bp_if.lookup_ghr), 32'hF9);
        check("rdold_next", 32'(bp_if.branchpredicted), 32'd1);

        // Statistics from a clean reset, then saturation on the 4-bit build.
        set_lookup(1'b0, 32'h0);
        pulse_rst();
        wait_init(1'b0, n_cyc);
        check("init_len2", 32'(n_cyc), 32'd256);
        check("stat_clr", bp_if.branch_count, 32'd0);
        for (int i = 0; i < 10; i++) begin
            set_upd(1'b1, 1'b1, 32'(i * 4), 8'h00, st_taken[i], st_pred[i]);
            tick();
        end
        set_upd(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        #1;
        check("stat_br", bp_if.branch_count, 32'd10);
        check("stat_mis", bp_if.mispredict_count, 32'd3);
        check("stat_br4", 32'(bp4_if.branch_count), 32'd10);
        check("stat_ghr", 32'(bp_if.lookup_ghr), 32'hCB);
        for (int i = 0; i < 10; i++) begin
            set_upd(1'b0, 1'b1, 32'h80, 8'h00, 1'b1, 1'b0);
            tick();
        end
        set_upd(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        #1;
        check("sat_br4", 32'(bp4_if.branch_count), 32'd15);
        check("sat_mis4", 32'(bp4_if.mispredict_count), 32'd13);
        check("stat_br_hold", bp_if.branch_count, 32'd10);

        // Reset in mid-init restarts the sweep; updates during init are dropped.
        set_upd(1'b1, 1'b1, 32'h80, 8'h00, 1'b1, 1'b0);
        pulse_rst();
        repeat (100) tick();
        check("mid_busy", 32'(bp_if.init_busy), 32'd1);
        pulse_rst();
        wait_init(1'b0, n_cyc);
        check("restart_len", 32'(n_cyc), 32'd256);
        check("init_ghr", 32'(bp_if.lookup_ghr), 32'd0);
        check("init_br", bp_if.branch_count, 32'd0);
        check("init_mis", bp_if.mispredict_count, 32'd0);
        check("init_br4", 32'(bp4_if.branch_count), 32'd0);
        set_upd(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
